data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Multi-cycle data-memory target for the pipelined CPU's memory stage. Takes the
//  MemRead/MemWrite/ByteSel/address/write-data requests the pipeline issues and
//  returns ReadData. Holds the pipeline with Stall for the duration of each access.
//  Word, half and byte accesses; little-endian byte lanes; sign-extended sub-word loads.
// PARAMETERS
//  DEPTH_WORDS  1024  storage depth in 32-bit words (power of 2, >=4)
//  LATENCY      2     BUSY cycles per access (>=1)
// PORTS
//  Clock      in   1   system clock, rising edge
//  Reset      in   1   asynchronous, active-high
//  MemRead    in   1   load request
//  MemWrite   in   1   store request (wins if MemRead also high)
//  ByteSel    in   2   00 word, 01 half, 10 byte, 11 treated as word
//  Address    in   32  byte address
//  WriteData  in   32  store data, low-aligned (byte in [7:0], half in [15:0])
//  ReadData   out  32  load result, sign-extended for half/byte
//  Stall      out  1   hold pipeline (combinational in IDLE, registered otherwise)
//  Done       out  1   one-cycle pulse, access complete
//  AddrErr    out  1   one-cycle pulse with Done, access was misaligned/out of range
// BEHAVIOUR
//  Reset: state=IDLE, ReadData=0, Done=0, AddrErr=0, Stall=0, counter=0.
//   Storage array is NOT cleared. Reset mid-access aborts it; a pending store does not modify memory.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: if MemRead|MemWrite: Stall=1 (comb.), latch op/ByteSel/Address/WriteData,
//   cnt<=LATENCY-1, go BUSY. Otherwise Stall=0.
//  BUSY: Stall=1; inputs ignored. If cnt!=0: decrement. If cnt==0: perform access, go DONE.
//  DONE: Stall=0, Done=1, ReadData valid. Inputs ignored (same instruction still presented).
//   Pipeline advances on this edge. Next request is accepted in the following IDLE cycle.
//  Timing: Stall high for 1+LATENCY cycles; Done in cycle 1+LATENCY after request (cycle 0).
//  Indexing: word = Address[log2(DEPTH_WORDS)+1:2]; lane = Address[1:0].
//  Error: AddrErr=1 if any of:
//   - Address bits above the index are nonzero
//   - word access with Address[1:0]!=0
//   - half access with Address[0]=1
//   On error: no write; a load returns ReadData=0.
//  Store: byte writes only lane Address[1:0]; half writes lanes {A[1],0} and {A[1],1};
//   word writes all four lanes. Untouched lanes keep their contents.
//  Load: byte -> sign-extend mem lane; half -> sign-extend 16 bits; word -> raw.
//   ReadData updates only on load completion and holds until the next load completes.
//   Stores leave ReadData unchanged.
//  Simultaneous MemRead & MemWrite: performed as a store only.
//  Back-to-back requests: the second request is taken in IDLE one cycle after DONE,
//   giving 2+LATENCY cycles per access.
// TESTING
//  T1 word store 0xDEADBEEF @0x10, then word load @0x10, LATENCY=2
//     -> Stall=1 for 3 cycles, Done at cycle 3, ReadData=0xDEADBEEF.
//  T2 byte store 0x80 @0x13, then byte load @0x13
//     -> ReadData=0xFFFFFF80; word load @0x10 -> 0x80ADBEEF.
//  T3 half load @0x11, and word load @0x12
//     -> AddrErr=1 with Done, ReadData=0, memory unchanged.
//  T4 load @ (DEPTH_WORDS*4)
//     -> AddrErr=1, ReadData=0. Store there -> AddrErr=1, word 0 unchanged.
//  T5 MemRead=MemWrite=1, word 0x12345678 @0x20
//     -> stored; ReadData keeps its previous value; subsequent load returns 0x12345678.
//  T6 assert Reset in BUSY of store 0xAAAA5555 @0x30
//     -> Stall/Done=0 immediately; load @0x30 returns prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory target for the CPU memory stage.
// Word/half/byte access, little-endian lanes, sign-extended sub-word loads.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  ByteSel,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        AddrErr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT             state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic              opWrite;
    logic [1:0]        selQ;
    logic [31:0]       addrQ;
    logic [31:0]       wdataQ;
    logic              errQ;
    logic              accept;
    logic              fire;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              isByte, isHalf, err;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [31:0]       memWord;
    logic [15:0]       halfVal;
    logic [7:0]        byteVal;
    logic [31:0]       loadVal;
    logic [3:0]        be;
    logic [31:0]       wLanes;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        Stall     = 1'b0;
        Done      = 1'b0;
        AddrErr   = 1'b0;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead | MemWrite) begin
                    Stall     = !Reset;
                    accept    = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (cnt == '0) begin
                    fire      = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                Done      = 1'b1;
                AddrErr   = errQ;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // ByteSel 2'b11 falls through to word size
    assign isByte  = (selQ == 2'b10);
    assign isHalf  = (selQ == 2'b01);
    assign idx     = addrQ[IDX_W+1:2];
    assign lane    = addrQ[1:0];
    assign err     = (|addrQ[31:IDX_W+2])
                   | (!isByte && !isHalf && (lane != 2'b00))
                   | (isHalf && addrQ[0]);
    assign memWord = mem[idx];
    assign halfVal = addrQ[1] ? memWord[31:16] : memWord[15:0];
    assign byteVal = memWord[{lane, 3'b000} +: 8];

    always_comb begin
        loadVal = memWord;
        be      = 4'b1111;
        wLanes  = wdataQ;
        if (isByte) begin
            loadVal = {{24{byteVal[7]}}, byteVal};
            be      = 4'b0001 << lane;
            wLanes  = {4{wdataQ[7:0]}};
        end else if (isHalf) begin
            loadVal = {{16{halfVal[15]}}, halfVal};
            be      = addrQ[1] ? 4'b1100 : 4'b0011;
            wLanes  = {2{wdataQ[15:0]}};
        end
    end

    always_ff @(posedge Clock) begin
        if (fire && opWrite && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wLanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            opWrite  <= 1'b0;
            selQ     <= 2'b00;
            addrQ    <= '0;
            wdataQ   <= '0;
            errQ     <= 1'b0;
            ReadData <= '0;
        end else begin
            if (accept) begin
                opWrite <= MemWrite;
                selQ    <= ByteSel;
                addrQ   <= Address;
                wdataQ  <= WriteData;
                cnt     <= CNT_W'(LATENCY - 1);
            end
            if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
            if (fire) begin
                errQ <= err;
                if (!opWrite) ReadData <= err ? 32'h0 : loadVal;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
// Directed vector table, reset-abort sequence, randomized model compare.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        MemRead, MemWrite;
    logic [1:0]  ByteSel;
    logic [31:0] Address, WriteData;
    logic [31:0] ReadData;
    logic        Stall, Done, AddrErr;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl [0:DEPTH*4-1];
    logic [31:0] mdlLast;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .Clock(Clock), .Reset(Reset), .MemRead(MemRead),
        .MemWrite(MemWrite), .ByteSel(ByteSel), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .Done(Done), .AddrErr(AddrErr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] expRd;
        logic        expErr;
    } vecT;

    vecT vecs[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: byte array, sizes and alignment from plain arithmetic
    function automatic void mdlRun(input logic wr, input logic rd,
                                   input logic [1:0] sel, input logic [31:0] a,
                                   input logic [31:0] wd,
                                   output logic [31:0] expRd, output logic expErr);
        int size;
        logic [31:0] v;
        size = (sel == 2'b10) ? 1 : (sel == 2'b01) ? 2 : 4;
        expErr = (a >= 32'(DEPTH*4)) || ((a % 32'(size)) != 0);
        v = 0;
        if (wr) begin
            if (!expErr)
                for (int i = 0; i < size; i++) mdl[a+32'(i)] = wd[8*i +: 8];
        end else if (rd) begin
            if (expErr) mdlLast = 0;
            else begin
                for (int i = 0; i < size; i++)
                    v = v | (32'(mdl[a+32'(i)]) << (8*i));
                if (size == 1) v = {{24{v[7]}}, v[7:0]};
                if (size == 2) v = {{16{v[15]}}, v[15:0]};
                mdlLast = v;
            end
        end
        expRd = mdlLast;
    endfunction

    task automatic doAccess(input logic wr, input logic rd, input logic [1:0] sel,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rdata, output logic err);
        int n;
        int st;
        @(negedge Clock);
        MemWrite  = wr;
        MemRead   = rd;
        ByteSel   = sel;
        Address   = a;
        WriteData = wd;
        #1;
        check("doneIdle", 32'(Done), 0);
        st = int'(Stall);
        n  = 0;
        while (!Done && n < 20) begin
            @(negedge Clock);
            n++;
            st += int'(Stall);
        end
        check("doneLatency", n, LAT + 1);
        check("stallCycles", st, LAT + 1);
        rdata    = ReadData;
        err      = AddrErr;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, expRd, prior;
        logic        er, expEr;
        int          r;
        logic [31:0] a;
        logic [1:0]  s;
        logic        w, q;

        Reset = 1'b1;
        MemRead = 0; MemWrite = 0; ByteSel = 0; Address = 0; WriteData = 0;
        mdlLast = 0;
        repeat (2) @(negedge Clock);
        check("rstStall", 32'(Stall), 0);
        check("rstDone", 32'(Done), 0);
        check("rstAddrErr", 32'(AddrErr), 0);
        check("rstReadData", ReadData, 0);
        Reset = 1'b0;

        vecs.push_back('{1'b1, 1'b0, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'd2, 32'h13, 32'h80, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h11, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h12, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h1000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'd0, 32'h0, 32'h11223344, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'd0, 32'h1000, 32'h55555555, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h11223344, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 32'h20, 32'h12345678, 32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h20, 32'h0, 32'h12345678, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd3, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'd1, 32'h22, 32'hFFFF7777, 32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h20, 32'h0, 32'h77775678, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'd2, 32'h21, 32'h123456AB, 32'h77775678, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h20, 32'h0, 32'h7777AB78, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'd0, 32'h22, 32'hFFFFFFFF, 32'h7777AB78, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h20, 32'h0, 32'h7777AB78, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h2, 32'h0, 32'h00001122, 1'b0});

        foreach (vecs[k]) begin
            doAccess(vecs[k].wr, vecs[k].rd, vecs[k].sel, vecs[k].addr,
                     vecs[k].wd, rd, er);
            mdlRun(vecs[k].wr, vecs[k].rd, vecs[k].sel, vecs[k].addr,
                   vecs[k].wd, expRd, expEr);
            check($sformatf("vec%0d.ReadData", k), rd, vecs[k].expRd);
            check($sformatf("vec%0d.AddrErr", k), 32'(er), 32'(vecs[k].expErr));
        end

        for (int i = 0; i < 16; i++) begin
            a = 32'(i * 4);
            r = int'($urandom);
            doAccess(1'b1, 1'b0, 2'd0, a, 32'(r), rd, er);
            mdlRun(1'b1, 1'b0, 2'd0, a, 32'(r), expRd, expEr);
            check("initErr", 32'(er), 32'(expEr));
        end

        prior = {mdl[51], mdl[50], mdl[49], mdl[48]};
        @(negedge Clock);
        MemWrite = 1'b1; ByteSel = 2'd0; Address = 32'h30; WriteData = 32'hAAAA5555;
        @(negedge Clock);
        check("abortBusyStall", 32'(Stall), 1);
        Reset = 1'b1;
        #1;
        check("abortStall", 32'(Stall), 0);
        check("abortDone", 32'(Done), 0);
        MemWrite = 1'b0;
        @(negedge Clock);
        check("abortReadData", ReadData, 0);
        Reset = 1'b0;
        mdlLast = 0;
        doAccess(1'b0, 1'b1, 2'd0, 32'h30, 32'h0, rd, er);
        mdlRun(1'b0, 1'b1, 2'd0, 32'h30, 32'h0, expRd, expEr);
        check("abortMemKept", rd, prior);
        check("abortMemModel", rd, expRd);

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r == 1) a = $urandom;
            else             a = 32'($urandom_range(0, 63));
            s = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 2));
            w = (r != 1);
            q = (r != 0);
            WriteData = $urandom;
            doAccess(w, q, s, a, WriteData, rd, er);
            mdlRun(w, q, s, a, WriteData, expRd, expEr);
            check($sformatf("rnd%0d.ReadData", i), rd, expRd);
            check($sformatf("rnd%0d.AddrErr", i), 32'(er), 32'(expEr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
